// File: rtl/prog_loader.sv
// Program loader: assembles a little-endian byte stream into 16-bit words held in a
// flop-based program store, and holds the core in reset until the whole program is in.
module prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          busy,
    output logic          done,
    output logic          core_rst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX_LO = 2'd1,
        RX_HI = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t        state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    lo_byte_reg;
    logic          in_ready_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          core_rst_reg;
    logic [15:0]   mem_reg [DEPTH];

    logic [AW:0]   len_eff;
    logic          xfer_hi;

    // A zero or oversized length means "fill the whole store".
    assign len_eff = ((len == '0) || (len > DEPTH_W)) ? DEPTH_W : len;
    assign xfer_hi = (state_reg == RX_HI) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            lo_byte_reg  <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            core_rst_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        count_reg    <= len_eff;
                        wr_ptr_reg   <= '0;
                        state_reg    <= RX_LO;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        done_reg     <= 1'b0;
                        core_rst_reg <= 1'b1;
                    end
                end
                RX_LO: begin
                    if (in_valid) begin
                        lo_byte_reg <= in_data;
                        state_reg   <= RX_HI;
                    end
                end
                RX_HI: begin
                    if (in_valid) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        count_reg  <= count_reg - 1'b1;
                        if (count_reg == ONE_W) begin
                            state_reg    <= DONE;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            core_rst_reg <= 1'b0;
                        end else begin
                            state_reg <= RX_LO;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The word is committed on the high-byte edge, so a reset between bytes never leaves a partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (xfer_hi) begin
            mem_reg[wr_ptr_reg] <= {in_data, lo_byte_reg};
        end
    end

    assign rd_data  = mem_reg[rd_addr];
    assign in_ready = in_ready_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign core_rst = core_rst_reg;

endmodule
